// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-addressed memory with byte lanes and a two-cycle ERROR response.
// Define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles before every OKAY completion.
module ahb_sram_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
`ifdef AHB_SLV_WAIT_EN
        , ST_WAIT = 2'd3
`endif
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   mem [DEPTH];

    logic          dp_valid;
    logic          dp_write;
    logic [3:0]    dp_be;
    logic [AW-1:0] dp_idx;

    logic          accept;
    logic          accept_ok;
    logic          accept_err;
    logic          range_bad;
    logic          size_bad;
    logic          misaligned;
    logic          req_err;
    logic [3:0]    req_be;
    logic          complete;

    logic          unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};

    // Only a cycle in which this slave is ready can start a new data phase.
    assign accept     = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign range_bad  = {2'b00, HADDR[31:2]} >= DEPTH;
    assign size_bad   = HSIZE > 3'd2;
    assign misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign req_err    = range_bad || size_bad || misaligned;
    assign accept_ok  = accept && !req_err;
    assign accept_err = accept && req_err;

    always_comb begin
        req_be = 4'b0000;
        case (HSIZE)
            3'd0:    req_be = 4'b0001 << HADDR[1:0];
            3'd1:    req_be = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    req_be = 4'b1111;
            default: req_be = 4'b0000;
        endcase
    end

`ifdef AHB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    logic [3:0] wait_cnt;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            wait_cnt <= 4'd0;
        end else if (accept_ok) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end
`else
    logic [3:0] unused_wait_states;
    assign unused_wait_states = 4'(WAIT_STATES);
`endif

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_ERR1: state_next = ST_ERR2;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: state_next = (wait_cnt == 4'd0) ? ST_IDLE : ST_WAIT;
`endif
            // IDLE and ERR2 are both ready cycles and may take the next transfer.
            default: begin
                if (accept_err) begin
                    state_next = ST_ERR1;
`ifdef AHB_SLV_WAIT_EN
                end else if (accept_ok && (WAIT_STATES > 0)) begin
                    state_next = ST_WAIT;
`endif
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: HREADYOUT = 1'b0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state    <= ST_IDLE;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_be    <= 4'b0000;
            dp_idx   <= '0;
        end else begin
            state <= state_next;
            if (accept_ok) begin
                dp_valid <= 1'b1;
                dp_write <= HWRITE;
                dp_be    <= req_be;
                dp_idx   <= HADDR[AW+1:2];
            end else if (complete) begin
                dp_valid <= 1'b0;
            end
        end
    end

    assign complete = dp_valid && (state == ST_IDLE);

    // Reads see the array directly, so a write completing on the previous edge is forwarded.
    assign HRDATA = (complete && !dp_write) ? mem[dp_idx] : 32'h0000_0000;

    always_ff @(posedge HCLK) begin
        if (complete && dp_write) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be[i]) begin
                    mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: pipelined directed and random AHB transfers against a word-array model.
// Expected wait count follows AHB_SLV_WAIT_EN.
module tb_ahb_sram_slave;
    localparam int DEPTH      = 256;
    localparam int WAITS      = 2;
    localparam int INIT_WORDS = 32;
`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAITS  = WAITS;
`else
    localparam int EXP_WAITS  = 0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        hclk   = 1'b0;
    logic        hreset = 1'b0;
    logic        hsel   = 1'b0;
    logic [31:0] haddr  = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize  = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot  = 4'd0;
    logic [31:0] hwdata = 32'h0;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    assign hready = hreadyout;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] ref_mem [DEPTH];
    xfer_t       seq_q [$];
    logic [31:0] last_rdata;
    logic        last_err;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WAITS)) dut (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready), .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp)
    );

    always #5 hclk = ~hclk;

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Error rule: size above a word, word index outside the memory, or address not a multiple of the size.
    function automatic logic ref_is_err(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if ((a >> 2) >= DEPTH) return 1'b1;
        return (a % (32'd1 << s)) != 32'd0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int first;
        int nbytes;
        first  = int'(a % 32'd4);
        nbytes = 1 << s;
        for (int b = first; b < first + nbytes; b++) begin
            ref_mem[a >> 2][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        xfer_t x;
        x.addr  = a;
        x.wr    = w;
        x.size  = s;
        x.wdata = d;
        seq_q.push_back(x);
    endtask

    // Runs the queued transfers back to back; entered and left at posedge+1.
    task automatic apply_stimulus();
        xfer_t       cur;
        logic        cur_valid;
        int          idx;
        int          stalls;
        logic        done;
        logic        exp_err;
        int          exp_stalls;
        logic [31:0] exp_rd;
        cur_valid = 1'b0;
        cur       = '0;
        idx       = 0;
        while ((idx < seq_q.size()) || cur_valid) begin
            if (idx < seq_q.size()) begin
                hsel   = 1'b1;
                htrans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                haddr  = seq_q[idx].addr;
                hwrite = seq_q[idx].wr;
                hsize  = seq_q[idx].size;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
            end
            hburst     = 3'($urandom);
            hprot      = 4'($urandom);
            hwdata     = cur_valid ? cur.wdata : $urandom;
            exp_err    = cur_valid && ref_is_err(cur.addr, cur.size);
            exp_stalls = !cur_valid ? 0 : (exp_err ? 1 : EXP_WAITS);
            stalls     = 0;
            done       = 1'b0;
            while (!done) begin
                @(negedge hclk);
                if (hreadyout) begin
                    done = 1'b1;
                end else begin
                    stalls++;
                    check_output("stall_hresp", 32'(hresp), 32'(exp_err));
                    check_output("stall_hrdata", hrdata, 32'h0);
                    if (stalls > 40) begin
                        check_output("ready_timeout", 32'(stalls), 32'(exp_stalls));
                        print_summary();
                        $finish;
                    end
                    @(posedge hclk);
                    #1;
                end
            end
            if (cur_valid) begin
                check_output("wait_cycles", 32'(stalls), 32'(exp_stalls));
                check_output("hresp", 32'(hresp), 32'(exp_err));
                exp_rd = (exp_err || cur.wr) ? 32'h0 : ref_mem[cur.addr >> 2];
                check_output("hrdata", hrdata, exp_rd);
                if (!exp_err && cur.wr) ref_write(cur.addr, cur.size, cur.wdata);
                last_rdata = hrdata;
                last_err   = hresp;
            end
            @(posedge hclk);
            #1;
            cur_valid = idx < seq_q.size();
            if (cur_valid) cur = seq_q[idx];
            idx++;
        end
        seq_q.delete();
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] old_word;
        int          r;

        #3;
        check_output("rst_hreadyout", 32'(hreadyout), 32'd1);
        check_output("rst_hresp", 32'(hresp), 32'd0);
        check_output("rst_hrdata", hrdata, 32'h0);
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hreset = 1'b1;

        for (int w = 0; w < INIT_WORDS; w++) push(32'(w * 4), 1'b1, 3'd2, $urandom);
        apply_stimulus();

        push(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        push(32'h10, 1'b0, 3'd2, 32'h0);
        apply_stimulus();
        check_output("word_rdwr", last_rdata, 32'hDEADBEEF);

        push(32'h10, 1'b1, 3'd2, 32'h11223344);
        push(32'h13, 1'b1, 3'd0, 32'hAA000000);
        push(32'h10, 1'b0, 3'd2, 32'h0);
        apply_stimulus();
        check_output("byte_lane_write", last_rdata, 32'hAA223344);

        push(32'h400, 1'b0, 3'd2, 32'h0);
        apply_stimulus();
        check_output("range_err_resp", 32'(last_err), 32'd1);
        check_output("range_err_rdata", last_rdata, 32'h0);

        old_word = ref_mem[8];
        push(32'h21, 1'b1, 3'd1, 32'h00BEEF00);
        push(32'h20, 1'b0, 3'd2, 32'h0);
        apply_stimulus();
        check_output("misaligned_no_write", last_rdata, old_word);

        push(32'h30, 1'b1, 3'd2, 32'h5);
        push(32'h30, 1'b0, 3'd2, 32'h0);
        apply_stimulus();
        check_output("forwarding", last_rdata, 32'h5);

        push(32'h24, 1'b0, 3'd3, 32'h0);
        push(32'h24, 1'b0, 3'd2, 32'h0);
        apply_stimulus();

        hsel   = 1'b1;
        htrans = 2'b01;
        hwrite = 1'b1;
        haddr  = 32'h30;
        hsize  = 3'd2;
        hwdata = 32'hFFFFFFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge hclk);
            check_output("nosel_busy_ready", 32'(hreadyout), 32'd1);
            check_output("nosel_busy_resp", 32'(hresp), 32'd0);
            @(posedge hclk);
            #1;
            if (c == 1) begin
                hsel   = 1'b0;
                htrans = 2'b10;
            end
        end
        hsel   = 1'b0;
        htrans = 2'b00;
        push(32'h30, 1'b0, 3'd2, 32'h0);
        apply_stimulus();
        check_output("busy_no_access", last_rdata, 32'h5);

        old_word = ref_mem[16];
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = 32'h40;
        hsize  = 3'd2;
        @(posedge hclk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = ~old_word;
        #2;
        check_output("pre_reset_ready", 32'(hreadyout), (EXP_WAITS == 0) ? 32'd1 : 32'd0);
        hreset = 1'b0;
        #1;
        check_output("async_rst_ready", 32'(hreadyout), 32'd1);
        check_output("async_rst_resp", 32'(hresp), 32'd0);
        check_output("async_rst_rdata", hrdata, 32'h0);
        @(posedge hclk);
        #1;
        hreset = 1'b1;
        push(32'h40, 1'b0, 3'd2, 32'h0);
        apply_stimulus();
        check_output("reset_discards_write", last_rdata, old_word);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 19);
            s = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, INIT_WORDS - 1)) * 32'd4 + 32'($urandom_range(0, 3));
            if (r < 14) a = a & ~((32'd1 << s) - 32'd1);
            if (r == 18) s = 3'd3;
            if (r == 19) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095)) * 32'd4;
            push(a, 1'($urandom), s, $urandom);
        end
        apply_stimulus();

        print_summary();
        $finish;
    end
endmodule
